// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution issue sequencer.
package conv_seq_pkg;

  localparam int DIM_W              = 8;
  localparam int PAD_W              = 2;
  localparam int STRIDE_W           = 3;
  localparam int FILT_W             = 8;
  localparam int NUM_ALLOCATORS_DEF = 220;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_POS,
    S_WAIT_POOL,
    S_ADVANCE,
    S_SWEEP,
    S_CHECK,
    S_FINISH
  } seq_state_e;

  // A layer is runnable only if it has a size, a step and at least one filter.
  function automatic logic cfg_valid(input logic [DIM_W-1:0]    dim,
                                     input logic [STRIDE_W-1:0] stride,
                                     input logic [FILT_W-1:0]   num_filters);
    return (dim != '0) && (stride != '0) && (num_filters != '0);
  endfunction

endpackage

// File: rtl/conv_issue_sequencer_sweep_timer.sv
// Down-counter that paces one positioner sweep. expired flags the tick that
// brings the count to its terminal value of 1, so the caller can leave on the
// same edge the count lands there.
module sweep_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] count;

  assign expired = tick && (count <= W'(2));

  // Load has priority over tick; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/conv_issue_sequencer.sv
// Layer-level controller for the issue positioner and its allocator pool.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no layer; positioner held in reset, start accepted here
// RESET_POS | one-cycle positioner reset with the latched config applied
// WAIT_POOL | waiting for the allocator pool to accept a batch
// ADVANCE   | one-cycle advance pulse; sweep timer loaded
// SWEEP     | positioner sweeping, timer counting down
// CHECK     | final sweep cycle; pos_done decides the next step
// FINISH    | one-cycle layer_done pulse
module conv_issue_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_ALLOCATORS = NUM_ALLOCATORS_DEF,
  parameter int SWEEP_W        = 9,
  parameter int BATCH_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DIM_W-1:0]    cfg_image_dim,
  input  logic [PAD_W-1:0]    cfg_padding,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic [FILT_W-1:0]   cfg_num_filters,
  input  logic                pool_ready,
  input  logic                pos_done,
  output logic [DIM_W-1:0]    pos_image_dim,
  output logic [PAD_W-1:0]    pos_padding,
  output logic [STRIDE_W-1:0] pos_stride,
  output logic                pos_rst,
  output logic                pos_advance,
  output logic                busy,
  output logic                layer_done,
  output logic                cfg_error,
  output logic [FILT_W-1:0]   filter_index,
  output logic [BATCH_W-1:0]  batch_count
);

  // The positioner sweep is NUM_ALLOCATORS+1 cycles after the advance: the
  // SWEEP state covers all but the last, which is the CHECK cycle.
  localparam logic [SWEEP_W-1:0] SWEEP_LEN = SWEEP_W'(NUM_ALLOCATORS + 1);

  seq_state_e        state;
  logic [FILT_W-1:0] num_filters_q;
  logic              timer_load;
  logic              timer_tick;
  logic              timer_expired;
  logic              cfg_ok;

  assign cfg_ok     = cfg_valid(cfg_image_dim, cfg_stride, cfg_num_filters);
  assign timer_load = (state == S_ADVANCE);
  assign timer_tick = (state == S_SWEEP);

  sweep_timer #(.W(SWEEP_W)) u_sweep_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (SWEEP_LEN),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // Moore outputs decoded from the registered state.
  assign pos_rst     = (state == S_IDLE) || (state == S_RESET_POS);
  assign pos_advance = (state == S_ADVANCE);
  assign busy        = (state != S_IDLE);
  assign layer_done  = (state == S_FINISH);

  // Sequencer FSM with config latch, filter/batch counters and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pos_image_dim <= '0;
      pos_padding   <= '0;
      pos_stride    <= '0;
      num_filters_q <= '0;
      filter_index  <= '0;
      batch_count   <= '0;
      cfg_error     <= 1'b0;
    end else begin
      cfg_error <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                pos_image_dim <= cfg_image_dim;
                pos_padding   <= cfg_padding;
                pos_stride    <= cfg_stride;
                num_filters_q <= cfg_num_filters;
                filter_index  <= '0;
                batch_count   <= '0;
                state         <= S_RESET_POS;
              end else begin
                cfg_error <= 1'b1;
              end
            end
          end
          S_RESET_POS: state <= S_WAIT_POOL;
          S_WAIT_POOL: begin
            if (pool_ready) state <= S_ADVANCE;
          end
          S_ADVANCE: begin
            if (batch_count != '1) batch_count <= batch_count + 1'b1;
            state <= S_SWEEP;
          end
          S_SWEEP: begin
            if (timer_expired) state <= S_CHECK;
          end
          S_CHECK: begin
            if (!pos_done) begin
              state <= S_WAIT_POOL;
            end else if (filter_index == num_filters_q - 1'b1) begin
              state <= S_FINISH;
            end else begin
              filter_index <= filter_index + 1'b1;
              state        <= S_RESET_POS;
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_issue_sequencer.sv
// Bench for conv_issue_sequencer: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_conv_issue_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_image_dim = '0;
  logic [1:0]  cfg_padding = '0;
  logic [2:0]  cfg_stride = '0;
  logic [7:0]  cfg_num_filters = '0;
  logic        pool_ready = 1'b0;
  logic        pos_done;
  logic [7:0]  pos_image_dim;
  logic [1:0]  pos_padding;
  logic [2:0]  pos_stride;
  logic        pos_rst;
  logic        pos_advance;
  logic        busy;
  logic        layer_done;
  logic        cfg_error;
  logic [7:0]  filter_index;
  logic [15:0] batch_count;

  conv_issue_sequencer #(.NUM_ALLOCATORS(N), .SWEEP_W(9), .BATCH_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg_image_dim   (cfg_image_dim),
    .cfg_padding     (cfg_padding),
    .cfg_stride      (cfg_stride),
    .cfg_num_filters (cfg_num_filters),
    .pool_ready      (pool_ready),
    .pos_done        (pos_done),
    .pos_image_dim   (pos_image_dim),
    .pos_padding     (pos_padding),
    .pos_stride      (pos_stride),
    .pos_rst         (pos_rst),
    .pos_advance     (pos_advance),
    .busy            (busy),
    .layer_done      (layer_done),
    .cfg_error       (cfg_error),
    .filter_index    (filter_index),
    .batch_count     (batch_count)
  );

  always #5 clk = ~clk;

  // Positioner stub: done once stub_k advances have been seen since its reset.
  logic [3:0] stub_cnt = '0;
  logic [3:0] stub_k = 4'd3;
  always_ff @(posedge clk) begin
    if (pos_rst) stub_cnt <= '0;
    else if (pos_advance && (stub_cnt != 4'hF)) stub_cnt <= stub_cnt + 1'b1;
  end
  assign pos_done = (stub_cnt >= stub_k);

  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a layer is reset pulse, then repeated
  // (wait for pool, advance, sweep of N+1 cycles counted from the advance).
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0, m_rstc = 1'b0, m_wait = 1'b0, m_adv = 1'b0;
  logic        m_fin = 1'b0, m_err = 1'b0;
  int          m_since = 0;
  logic [7:0]  m_dim = '0, m_nf = '0, m_filt = '0;
  logic [1:0]  m_pad = '0;
  logic [2:0]  m_stride = '0;
  logic [15:0] m_batch = '0;

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_rstc = 0; m_wait = 0; m_adv = 0; m_fin = 0; m_err = 0;
      m_since = 0; m_dim = 0; m_nf = 0; m_filt = 0; m_pad = 0; m_stride = 0;
      m_batch = 0;
    end else begin
      m_err = 0;
      if (!m_busy) begin
        if (start) begin
          if (cfg_image_dim != 0 && cfg_stride != 0 && cfg_num_filters != 0) begin
            m_dim = cfg_image_dim; m_pad = cfg_padding; m_stride = cfg_stride;
            m_nf = cfg_num_filters; m_filt = 0; m_batch = 0;
            m_busy = 1; m_rstc = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (abort) begin
        m_busy = 0; m_rstc = 0; m_wait = 0; m_adv = 0; m_fin = 0; m_since = 0;
      end else if (m_fin) begin
        m_fin = 0; m_busy = 0;
      end else if (m_rstc) begin
        m_rstc = 0; m_wait = 1;
      end else if (m_wait) begin
        if (pool_ready) begin m_wait = 0; m_adv = 1; end
      end else if (m_adv) begin
        m_adv = 0; m_since = 1;
        if (m_batch != 16'hFFFF) m_batch = m_batch + 16'd1;
      end else if (m_since <= N) begin
        m_since++;
      end else begin
        m_since = 0;
        if (!pos_done) m_wait = 1;
        else if (int'(m_filt) == int'(m_nf) - 1) m_fin = 1;
        else begin m_filt = m_filt + 8'd1; m_rstc = 1; end
      end
    end
    m_valid = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int ncyc = 0;
  initial forever begin
    @(posedge clk);
    ncyc++;
  end

  // Per-cycle compare against the model plus event recording for scenarios.
  int adv_q[$];
  int fi_q[$];
  int ld_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("pos_rst",       pos_rst,       (!m_busy) || m_rstc);
      chk("pos_advance",   pos_advance,   m_adv);
      chk("busy",          busy,          m_busy);
      chk("layer_done",    layer_done,    m_fin);
      chk("cfg_error",     cfg_error,     m_err);
      chk("pos_image_dim", pos_image_dim, m_dim);
      chk("pos_padding",   pos_padding,   m_pad);
      chk("pos_stride",    pos_stride,    m_stride);
      chk("filter_index",  filter_index,  m_filt);
      chk("batch_count",   batch_count,   m_batch);
      if (pos_advance) adv_q.push_back(ncyc);
      if (pos_rst && busy) fi_q.push_back(int'(filter_index));
      if (layer_done) ld_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    adv_q.delete();
    fi_q.delete();
    ld_cnt = 0;
  endtask

  task automatic start_layer(input logic [7:0] dim, input logic [1:0] pad,
                             input logic [2:0] stride, input logic [7:0] nf,
                             output int c_start);
    @(negedge clk);
    cfg_image_dim = dim; cfg_padding = pad; cfg_stride = stride; cfg_num_filters = nf;
    start = 1'b1;
    c_start = ncyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (ld_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("layer_done_within_budget", (ld_cnt > 0), 1);
  endtask

  initial begin
    int c0;
    int r;
    cycles(3);
    chk("reset_pos_rst", pos_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_batch", batch_count, 0);
    rst = 1'b0;
    cycles(2);

    // Single filter, three sweeps.
    stub_k = 4'd3; pool_ready = 1'b1;
    clear_log();
    start_layer(8'd8, 2'd1, 3'd1, 8'd1, c0);
    wait_done(200);
    cycles(3);
    chk("t1_adv_count", adv_q.size(), 3);
    if (adv_q.size() >= 3) begin
      chk("t1_first_adv_latency", adv_q[0] - c0, 3);
      chk("t1_gap1", adv_q[1] - adv_q[0], 7);
      chk("t1_gap2", adv_q[2] - adv_q[1], 7);
    end
    chk("t1_batch", batch_count, 3);
    chk("t1_layer_done_cnt", ld_cnt, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_padding", pos_padding, 1);

    // Three filters, two sweeps each.
    stub_k = 4'd2;
    clear_log();
    start_layer(8'd16, 2'd2, 3'd2, 8'd3, c0);
    wait_done(400);
    cycles(3);
    chk("t2_reset_pulses", fi_q.size(), 3);
    if (fi_q.size() == 3) begin
      chk("t2_fi0", fi_q[0], 0);
      chk("t2_fi1", fi_q[1], 1);
      chk("t2_fi2", fi_q[2], 2);
    end
    chk("t2_batch", batch_count, 6);
    chk("t2_layer_done_cnt", ld_cnt, 1);
    chk("t2_filter_index_hold", filter_index, 2);

    // Pool backpressure, then abort mid-sweep.
    stub_k = 4'd1; pool_ready = 1'b0;
    clear_log();
    start_layer(8'd4, 2'd0, 3'd1, 8'd1, c0);
    cycles(21);
    chk("t3_no_adv_during_hold", adv_q.size(), 0);
    chk("t3_busy_during_hold", busy, 1);
    pool_ready = 1'b1;
    r = ncyc;
    cycles(3);
    chk("t3_adv_seen", adv_q.size(), 1);
    if (adv_q.size() >= 1) chk("t3_adv_after_ready", adv_q[0] - r, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_pos_rst", pos_rst, 1);
    chk("t4_abort_batch_hold", batch_count, 1);
    cycles(2);
    chk("t4_abort_no_done", ld_cnt, 0);
    start_layer(8'd6, 2'd1, 3'd1, 8'd1, c0);
    chk("t4_restart_busy", busy, 1);
    wait_done(100);
    chk("t4_restart_batch", batch_count, 1);

    // Rejected config.
    cycles(2);
    @(negedge clk);
    cfg_image_dim = 8'd5; cfg_stride = 3'd0; cfg_num_filters = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_cfg_error", cfg_error, 1);
    chk("t5_busy", busy, 0);
    chk("t5_stride_kept", pos_stride, 1);
    chk("t5_dim_kept", pos_image_dim, 6);
    @(negedge clk);
    chk("t5_cfg_error_single", cfg_error, 0);

    // Start while busy, then reset mid-layer.
    pool_ready = 1'b0;
    clear_log();
    start_layer(8'd9, 2'd3, 3'd4, 8'd2, c0);
    cfg_image_dim = 8'd99; cfg_stride = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(2);
    chk("t6_busy_start_dim", pos_image_dim, 9);
    chk("t6_busy_start_stride", pos_stride, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_pos_rst", pos_rst, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_dim", pos_image_dim, 0);
    chk("t6_rst_filter", filter_index, 0);
    chk("t6_rst_no_done", ld_cnt, 0);

    // Randomized traffic, checked by the per-cycle model compare.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 499) == 0);
      abort           = ($urandom_range(0, 79) == 0);
      start           = ($urandom_range(0, 5) == 0);
      cfg_image_dim   = 8'($urandom_range(0, 3));
      cfg_padding     = 2'($urandom_range(0, 3));
      cfg_stride      = 3'($urandom_range(0, 2));
      cfg_num_filters = 8'($urandom_range(0, 3));
      pool_ready      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) stub_k = 4'($urandom_range(1, 3));
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_issue_sequencer.md
Name: conv_issue_sequencer

Overview:
- Layer-level controller for the issue positioner and its allocator pool.
- Accepts a convolution layer configuration through a start handshake and latches it.
- Drives the positioner's configuration, reset and advance inputs, paces advances against positioner sweep time and allocator-pool readiness, and loops the full position sweep once per filter.
- Sits between the host/config interface and the positioner; reports busy, per-layer completion and config errors.

Parameters:
- NUM_ALLOCATORS, 220, allocator count of the driven positioner; one sweep after an advance lasts NUM_ALLOCATORS+1 cycles.
- SWEEP_W, 9, width of the sweep timer; must hold NUM_ALLOCATORS+1.
- BATCH_W, 16, width of batch_count.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a layer; sampled only in IDLE.
- abort  in  1  synchronous abort of the current layer.
- cfg_image_dim  in  8  input image dimension.
- cfg_padding  in  2  padding.
- cfg_stride  in  3  stride.
- cfg_num_filters  in  8  number of full sweeps (filters) to run.
- pool_ready  in  1  allocator pool idle; may accept a new batch.
- pos_done  in  1  positioner done flag.
- pos_image_dim  out  8  latched image_dim to positioner.
- pos_padding  out  2  latched padding.
- pos_stride  out  3  latched stride.
- pos_rst  out  1  positioner reset.
- pos_advance  out  1  positioner advance pulse.
- busy  out  1  high in any state except IDLE.
- layer_done  out  1  one-cycle pulse when the last filter completes.
- cfg_error  out  1  one-cycle pulse when start is rejected.
- filter_index  out  8  current filter, 0-based.
- batch_count  out  BATCH_W  advances issued this layer; saturating.

Behaviour:
- Reset values:
  - State is IDLE.
  - pos_rst=1.
  - All other outputs are 0, including the latched config, filter_index and batch_count.
- All outputs are registered or Moore-decoded from the registered state. There is no combinational path from inputs to outputs.
- States: IDLE, RESET_POS, WAIT_POOL, ADVANCE, SWEEP, CHECK, FINISH.
- IDLE:
  - pos_rst=1.
  - start=1 with dim!=0, stride!=0, num_filters!=0: latch config, clear filter_index and batch_count, go to RESET_POS.
  - start=1 with any of those fields zero: pulse cfg_error on the next cycle, stay in IDLE, leave latched config unchanged.
- RESET_POS:
  - Lasts one cycle with pos_rst=1.
  - The latched config is already stable on pos_* during this cycle, so the positioner resets with the correct padding.
  - Then go to WAIT_POOL.
- WAIT_POOL: pos_rst=0. When pool_ready=1, go to ADVANCE; otherwise stay indefinitely.
- ADVANCE:
  - pos_advance=1 for exactly one cycle.
  - batch_count increments, saturating at all-ones.
  - Load the sweep timer with NUM_ALLOCATORS+1, then go to SWEEP.
- SWEEP:
  - The timer decrements each cycle.
  - When the timer reaches 1, go to CHECK.
  - The sweep occupies exactly NUM_ALLOCATORS+1 cycles; pos_advance stays low throughout.
- CHECK:
  - One cycle; samples pos_done.
  - pos_done=0: go to WAIT_POOL.
  - pos_done=1 and filter_index==num_filters-1: go to FINISH.
  - pos_done=1 otherwise: increment filter_index and go to RESET_POS.
- FINISH: layer_done=1 for one cycle, then go to IDLE. filter_index and batch_count hold their values until the next accepted start.
- Advance spacing: advance-to-advance spacing is at least NUM_ALLOCATORS+3 cycles, which the positioner requires.
- Latency: start at edge T gives
  - RESET_POS in cycle T+1;
  - WAIT_POOL in cycle T+2;
  - the first pos_advance no earlier than cycle T+3.
- abort:
  - In any non-IDLE state, abort=1 forces IDLE on the next edge.
  - pos_rst is reasserted; no layer_done pulse.
  - Counters hold their values.
  - abort in IDLE is ignored. abort wins over every other transition.
- start while busy is ignored; no error pulse.
- Simultaneous start and abort in IDLE: start is processed.
- rst mid-layer: immediate return to reset values; no layer_done pulse.
- pos_done is examined only in CHECK. A pos_done seen during SWEEP has no effect until CHECK.

Decomposition:
- Package conv_seq_pkg holds:
  - state enum/localparams for the 7 states;
  - config field widths (DIM_W=8, PAD_W=2, STRIDE_W=3, FILT_W=8);
  - the default NUM_ALLOCATORS.
- Sub-module sweep_timer (load, value, tick; expired flag) holds the SWEEP down-counter. It is reusable by other schedulers.

Test Plan:
- Single filter, 3 sweeps: bench uses a positioner stub (NUM_ALLOCATORS=4) that raises pos_done after the 3rd advance; cfg dim=8, pad=1, stride=1, filters=1; pool_ready=1.
  - Expect 3 pos_advance pulses spaced exactly 7 cycles apart.
  - layer_done pulses once; batch_count=3; pos_rst high in IDLE and RESET_POS only.
- Multi-filter: filters=3, stub done after 2 advances per reset.
  - filter_index steps 0,1,2.
  - pos_rst pulses between filters.
  - batch_count=6; exactly one layer_done.
- Backpressure: hold pool_ready=0 for 20 cycles in WAIT_POOL.
  - No pos_advance during the hold.
  - Advance occurs 1 cycle after pool_ready rises.
- Config error: start with stride=0.
  - cfg_error pulses 1 cycle; busy stays 0; pos_* unchanged.
- Abort mid-SWEEP: assert abort.
  - Next cycle: state IDLE, pos_rst=1, busy=0, no layer_done.
  - A new start is accepted afterwards.
- Reset mid-layer and busy start: rst during WAIT_POOL gives all outputs at reset values, pos_rst=1. Separately, start pulsed while busy has no effect on the latched config.
